// File: rtl/regfile_scanner_if.sv
// Output stream of the register-dump sequencer: one {index, value} pair per
// valid/ready handshake.
interface regfile_scanner_if #(
  parameter int unsigned DATA_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [4:0]        out_idx;
  logic [DATA_W-1:0] out_data;

  modport master (
    output out_valid,
    output out_idx,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_idx,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/regfile_scanner.sv
// Register-dump sequencer: on start, stalls the CPU, takes over regfile read
// port A and streams {index, value} pairs for registers 0..NUM_REGS-1.
module regfile_scanner #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [4:0]        cpu_rs1,
  output logic [4:0]        rs1_out,
  input  logic [DATA_W-1:0] regA,
  output logic              cpu_stall,
  output logic              done,
  regfile_scanner_if.master out_if
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ADDR  = 2'd1;
  localparam logic [1:0] VALID = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  logic [1:0]        state;
  logic [4:0]        idx;
  logic [4:0]        out_idx_q;
  logic [DATA_W-1:0] out_data_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      out_idx_q  <= '0;
      out_data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= ADDR;
            idx   <= '0;
          end
        end
        ADDR: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            // regA is the combinational read of idx driven on rs1_out this cycle
            out_data_q <= regA;
            out_idx_q  <= idx;
            state      <= VALID;
          end
        end
        VALID: begin
          if (abort) begin
            state <= IDLE;
          end else if (out_if.out_ready) begin
            if (idx == LAST_IDX) begin
              state <= DONE;
            end else begin
              idx   <= idx + 5'd1;
              state <= ADDR;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // All status outputs decode registered state only; rs1_out is the sole
  // combinational path, and only from cpu_rs1 while not scanning.
  assign cpu_stall        = (state == ADDR) || (state == VALID);
  assign done             = (state == DONE);
  assign out_if.out_valid = (state == VALID);
  assign out_if.out_idx   = out_idx_q;
  assign out_if.out_data  = out_data_q;
  assign rs1_out          = cpu_stall ? idx : cpu_rs1;

endmodule

// File: tb/tb_regfile_scanner.sv
// Self-checking bench for regfile_scanner: directed tables, corner-case
// sequences and randomized scans against a behavioural regfile/stream model.
module tb_regfile_scanner;

  localparam int NUM = 32;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [4:0]  cpu_rs1;
  logic [4:0]  rs1_out;
  logic [31:0] regA;
  logic        cpu_stall;
  logic        done;

  logic [31:0] regs [NUM];

  int n_cmp = 0;
  int n_err = 0;

  regfile_scanner_if #(.DATA_W(32)) sif ();

  regfile_scanner #(
    .NUM_REGS(NUM),
    .DATA_W  (32)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .cpu_rs1  (cpu_rs1),
    .rs1_out  (rs1_out),
    .regA     (regA),
    .cpu_stall(cpu_stall),
    .done     (done),
    .out_if   (sif)
  );

  always #5 clock = ~clock;

  // behavioural regfile: combinational read of whatever address is presented
  assign regA = regs[rs1_out];

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] exp_rs1;
    logic       exp_stall;
    logic       exp_valid;
  } vec_t;

  vec_t tbl [NUM];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic preload();
    for (int i = 0; i < NUM; i++) regs[i] = 32'h0;
    regs[1]  = 32'd5;
    regs[7]  = 32'hFFFF_FFFD;
    regs[31] = 32'h7FFF_FFFF;
  endtask

  task automatic rand_regs();
    for (int i = 0; i < NUM; i++) regs[i] = $urandom;
    regs[0] = 32'h0;
  endtask

  task automatic start_scan();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called in the first cycle after the start edge. Returns the cycle number
  // (1 = first stall cycle) in which done was seen, or -1 on timeout.
  // mode 0: ready always 1; 1: ready 1,0,0 pattern; 2: random ready and cpu_rs1.
  task automatic run_scan(input int mode, input bit poke, output int dcyc);
    int next;
    int last_hs;
    int stalls;
    int dones;
    int pat;
    bit hold_pend;
    bit poked_valid;
    logic [4:0]  h_idx;
    logic [31:0] h_data;
    next = 0; last_hs = -10; stalls = 0; dones = 0; pat = 0;
    hold_pend = 1'b0; poked_valid = 1'b0; dcyc = -1;
    h_idx = '0; h_data = '0;
    for (int c = 1; c <= 400; c++) begin
      if (cpu_stall) stalls++;
      if (sif.out_valid) begin
        chk("pair_idx", sif.out_idx, next[4:0]);
        chk("pair_data", sif.out_data, regs[next]);
        chk("valid_rs1", rs1_out, sif.out_idx);
        if (hold_pend) begin
          chk("hold_idx", sif.out_idx, h_idx);
          chk("hold_data", sif.out_data, h_data);
        end
      end else if (!cpu_stall) begin
        chk("free_rs1", rs1_out, cpu_rs1);
      end
      if (done) begin
        dones++;
        dcyc = c;
        chk("done_after_last", c, last_hs + 1);
      end
      case (mode)
        0: sif.out_ready = 1'b1;
        1: sif.out_ready = (pat % 3 == 0);
        default: begin
          sif.out_ready = $urandom_range(1);
          cpu_rs1       = 5'($urandom_range(31));
        end
      endcase
      pat++;
      start = 1'b0;
      if (poke && sif.out_valid && !poked_valid) begin
        start = 1'b1;
        poked_valid = 1'b1;
      end
      if (poke && done) start = 1'b1;
      if (sif.out_valid && sif.out_ready) begin
        last_hs = c;
        next++;
      end
      hold_pend = sif.out_valid && !sif.out_ready;
      h_idx = sif.out_idx;
      h_data = sif.out_data;
      tick();
      if (dcyc != -1) break;
    end
    start = 1'b0;
    chk("scan_finished", (dcyc != -1), 1);
    chk("pairs_count", next, NUM);
    chk("done_count", dones, 1);
    chk("stall_cycles", stalls, dcyc - 1);
    chk("after_done_stall", cpu_stall, 1'b0);
    chk("after_done_pulse", done, 1'b0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    bit found;
    reset = 1'b1; start = 1'b0; abort = 1'b0; cpu_rs1 = 5'd9;
    sif.out_ready = 1'b0;
    preload();
    tick(); tick();

    chk("rst_valid", sif.out_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_stall", cpu_stall, 1'b0);
    chk("rst_idx", sif.out_idx, 5'd0);
    chk("rst_data", sif.out_data, 32'd0);
    chk("rst_rs1", rs1_out, 5'd9);
    reset = 1'b0;
    tick();

    // idle transparency sweep
    for (int i = 0; i < NUM; i++) begin
      tbl[i].rs1 = 5'(i); tbl[i].exp_rs1 = 5'(i);
      tbl[i].exp_stall = 1'b0; tbl[i].exp_valid = 1'b0;
    end
    for (int i = 0; i < NUM; i++) begin
      cpu_rs1 = tbl[i].rs1;
      #1;
      chk("idle_rs1", rs1_out, tbl[i].exp_rs1);
      tick();
      chk("idle_stall", cpu_stall, tbl[i].exp_stall);
      chk("idle_valid", sif.out_valid, tbl[i].exp_valid);
    end

    // full scan, ready held high
    preload();
    cpu_rs1 = 5'd4;
    sif.out_ready = 1'b1;
    start_scan();
    chk("first_stall", cpu_stall, 1'b1);
    chk("first_not_valid", sif.out_valid, 1'b0);
    run_scan(0, 1'b0, d);
    chk("done_cycle_full", d, 65);

    // ready toggling 1,0,0
    preload();
    start_scan();
    run_scan(1, 1'b0, d);

    // abort in VALID at pair 10 with ready high
    preload();
    sif.out_ready = 1'b1;
    start_scan();
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (sif.out_valid && sif.out_idx == 5'd10) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("abort_reach", found, 1'b1);
    abort = 1'b1; cpu_rs1 = 5'd3; sif.out_ready = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", sif.out_valid, 1'b0);
    chk("abort_stall", cpu_stall, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_rs1", rs1_out, 5'd3);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("abort_no_done", done, 1'b0);
      chk("abort_idle", cpu_stall, 1'b0);
    end

    // reset while in ADDR with idx 20
    rand_regs();
    sif.out_ready = 1'b1;
    start_scan();
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (cpu_stall && !sif.out_valid && rs1_out == 5'd20) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("reset_reach", found, 1'b1);
    cpu_rs1 = 5'd17;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", sif.out_valid, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_stall", cpu_stall, 1'b0);
    chk("mid_rst_idx", sif.out_idx, 5'd0);
    chk("mid_rst_data", sif.out_data, 32'd0);
    chk("mid_rst_rs1", rs1_out, 5'd17);
    tick();
    start_scan();
    run_scan(0, 1'b0, d);
    chk("rescan_done_cycle", d, 65);

    // start pulsed in VALID and in DONE: ignored; start in next IDLE accepted
    preload();
    start_scan();
    run_scan(0, 1'b1, d);
    chk("poke_done_cycle", d, 65);
    tick();
    chk("poke_still_idle", cpu_stall, 1'b0);
    chk("poke_no_done", done, 1'b0);
    start_scan();
    chk("idle_start_ok", cpu_stall, 1'b1);
    run_scan(1, 1'b0, d);

    // randomized scans
    for (int r = 0; r < 4; r++) begin
      rand_regs();
      cpu_rs1 = 5'($urandom_range(31));
      for (int g = 0; g < int'($urandom_range(3)); g++) tick();
      start_scan();
      run_scan(2, 1'b0, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_scanner.md
# regfile_scanner

Hardware register-dump sequencer for the processor's register file. On `start` it freezes the CPU, takes over the regfile read port A, and walks registers 0..NUM_REGS-1. It streams each `{index, value}` pair out over a valid/ready handshake, e.g. to a UART or debug display on the board. When idle it is transparent: port A address passes straight from the processor.

## Interface
- `NUM_REGS`, 32, number of registers scanned, indices 0..NUM_REGS-1; legal range 2..32.
- `DATA_W`, 32, register data width.
- `clock`  in  1  single system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high; forces IDLE.
- `start`  in  1  request a scan; sampled only in IDLE.
- `abort`  in  1  cancel an in-progress scan.
- `cpu_rs1`  in  5  processor's port-A read address.
- `rs1_out`  out  5  address driven to regfile `ctrl_readRegA`.
- `regA`  in  DATA_W  regfile `data_readRegA` (combinational read of `rs1_out`).
- `cpu_stall`  out  1  high while a scan is in progress; processor must hold PC and suppress `ctrl_writeEnable`/`wren`.
- `out_valid`  out  1  `out_idx`/`out_data` hold a valid pair.
- `out_ready`  in  1  downstream accepts the pair.
- `out_idx`  out  5  register index of the current pair.
- `out_data`  out  DATA_W  captured register value.
- `done`  out  1  one-cycle pulse after the last pair is accepted.

## Operation
- States: IDLE, ADDR, VALID, DONE; 5-bit index counter `idx`.
- IDLE:
  - `start`=1 -> ADDR, `idx`=0.
  - Otherwise stay.
- ADDR:
  - `rs1_out`=`idx`.
  - At the edge, capture `regA` into `out_data` and `idx` into `out_idx`, then -> VALID.
- VALID:
  - `out_valid`=1; `rs1_out`=`idx`.
  - `out_idx`/`out_data` are stable until the handshake.
  - `out_ready`=1 with `idx`<NUM_REGS-1 -> `idx`+1, ADDR.
  - `out_ready`=1 with `idx`=NUM_REGS-1 -> DONE.
  - `out_ready`=0 -> stay.
- DONE: `done`=1 for this cycle only, then -> IDLE unconditionally.
- `abort` in ADDR or VALID:
  - -> IDLE next edge; no `done` pulse.
  - `out_valid` drops without a handshake; the downstream discards any partial dump.
  - `abort` in IDLE or DONE is ignored.
  - `abort` has priority over `out_ready` in the same cycle.
- `start` outside IDLE is ignored, including in DONE; no queuing.
- `rs1_out` = `cpu_rs1` in IDLE and DONE, else `idx`.
- `cpu_stall` = 1 in ADDR and VALID, 0 in IDLE and DONE.
- Register 0 is scanned like any other and its read value is reported as-is (expected 0).
- `idx` never exceeds NUM_REGS-1; no wrap-around path exists.

## Timing
- Reset (synchronous, checked at each edge):
  - State IDLE, `idx`=0.
  - `out_valid`=0, `done`=0, `cpu_stall`=0.
  - `out_idx`=0, `out_data`=0.
  - `rs1_out`=`cpu_rs1`.
  - Reset in any state, including mid-scan, returns to IDLE on that edge; no `done`.
- Start and ready latency:
  - `start` sampled at edge E0 -> `cpu_stall`=1 and ADDR in cycle after E0.
  - First `out_valid` one cycle later.
  - Each pair costs 2 cycles with `out_ready` held high (ADDR + VALID).
  - A full 32-register scan takes 64 cycles from the first stall cycle to `done`; `done` is in cycle 65 after E0.
- Pair acceptance:
  - A pair is transferred on an edge where `out_valid` and `out_ready` are both 1.
  - `out_ready` may be high before `out_valid`; this has no effect.
- Outputs and the stall path:
  - `out_valid`, `done`, `cpu_stall` are decoded from registered state; no combinational path from `out_ready` or `start`.
  - `rs1_out` depends combinationally on `cpu_rs1` only in IDLE and DONE.
- Back-to-back scans: a new `start` is accepted at the earliest in the IDLE cycle following DONE.

## Test plan
- Preload r1=5, r7=-3, r31=0x7FFFFFFF, others 0; pulse `start`, `out_ready`=1.
  - Required: 32 pairs in order 0..31 with matching values.
  - Required: `done` pulses 65 cycles after the start edge, `cpu_stall` high for exactly 64 cycles.
- Same preload, `out_ready` toggling 1,0,0,1,... from a fixed pattern.
  - Required: `out_idx`/`out_data` never change while `out_valid`=1 and `out_ready`=0.
  - Required: all 32 pairs delivered exactly once.
- Assert `abort` in VALID with `out_idx`=10 and `out_ready`=1 on the same cycle.
  - Required: IDLE next cycle, no `done`, no pair 10 handshake.
  - Required: `rs1_out` follows `cpu_rs1`=3.
- Assert `reset` while in ADDR with `idx`=20.
  - Required: all outputs at reset values next cycle.
  - Required: a subsequent `start` dumps from index 0.
- Pulse `start` while in VALID and again in the DONE cycle.
  - Required: both ignored; exactly one `done`.
  - Required: a `start` in the following IDLE cycle begins a new scan.
- Idle transparency: sweep `cpu_rs1` 0..31 with `start`=0.
  - Required: `rs1_out`=`cpu_rs1` every cycle.
  - Required: `cpu_stall`=0, `out_valid`=0 throughout.
